// File: rtl/counters_pkg.sv
// Shared definitions for the counter library.
// State encodings are common to every counter FSM in the library.
package counters_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_RUN  = ENC_RUN,
        ST_DONE = ENC_DONE
    } timer_state_t;

endpackage

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot or periodic terminal-count pulse.
// A loaded period is counted toward zero; tc pulses for one cycle on expiry.
module down_timer
    import counters_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state;
    logic [WIDTH-1:0] reload_q;
    logic             start_req;
    logic             stop_req;

    // Simultaneous start and stop cancel each other out.
    assign start_req = start & ~stop;
    assign stop_req  = stop & ~start;

    always_ff @(posedge clk) begin
        tc <= 1'b0;
        if (rst) begin
            state    <= ST_IDLE;
            count    <= ZERO;
            reload_q <= ZERO;
        end else if (load) begin
            state    <= ST_IDLE;
            count    <= load_val;
            reload_q <= load_val;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (count != ZERO) begin
                            state <= ST_RUN;
                        end else begin
                            tc    <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state <= ST_IDLE;
                    end else if (en && count != ZERO) begin
                        // Expiry happens on the 1 -> 0 step, never below zero.
                        if (count == ONE) begin
                            tc <= 1'b1;
                            if (auto_reload) begin
                                count <= reload_q;
                            end else begin
                                count <= ZERO;
                                state <= ST_DONE;
                            end
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (start_req) begin
                        if (reload_q != ZERO) begin
                            count <= reload_q;
                            state <= ST_RUN;
                        end else begin
                            tc <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random traffic
// compared against a behavioural model of the timer rules.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model: remaining ticks, saved period and a phase name.
    int    m_count = 0;
    int    m_period = 0;
    string m_phase = "idle";
    bit    m_tc = 0;

    down_timer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] expected();
        return {m_count[7:0], m_phase == "run", m_phase == "done", m_tc};
    endfunction

    task automatic model_step();
        m_tc = 0;
        if (rst) begin
            m_count = 0; m_period = 0; m_phase = "idle";
        end else if (load) begin
            m_count = int'(load_val); m_period = int'(load_val); m_phase = "idle";
        end else if (start && !stop && m_phase == "idle") begin
            if (m_count > 0) m_phase = "run";
            else begin m_tc = 1; m_phase = "done"; end
        end else if (start && !stop && m_phase == "done") begin
            if (m_period > 0) begin m_count = m_period; m_phase = "run"; end
            else m_tc = 1;
        end else if (stop && !start && m_phase == "run") begin
            m_phase = "idle";
        end else if (m_phase == "run" && en && m_count > 0) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_tc = 1;
                if (auto_reload) m_count = m_period;
                else m_phase = "done";
            end
        end
    endtask

    task automatic tick(input logic r, input logic ld, input logic [7:0] lv,
                        input logic st, input logic sp, input logic e, input logic ar);
        @(negedge clk);
        rst = r; load = ld; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 8'd0, 0, 0, 0, 0);
        tick(1, 0, 8'd0, 0, 0, 0, 0);
        n_checks++;
        if ({count, busy, done, tc} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b required %b", {count, busy, done, tc}, 11'd0);
        end
        tick(0, 1, 8'd5, 0, 0, 1, 0);
        n_checks++;
        if ({count, busy, done, tc} !== {8'd5, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL load5: got %b required %b", {count, busy, done, tc}, {8'd5, 3'b000});
        end
    endtask

    task automatic test_one_shot();
        int tc_at;
        int exp_cnt;
        tc_at = -1;
        tick(0, 1, 8'd5, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 0, 8'd0, i == 1, 0, 1, 0);
            if (tc) tc_at = i;
            exp_cnt = (i <= 6) ? 6 - i : 0;
            n_checks++;
            if (count !== 8'(exp_cnt) || {count, busy, done, tc} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL one_shot_cycle%0d: got cnt=%0d busy=%b done=%b tc=%b required cnt=%0d model=%b",
                         i, count, busy, done, tc, exp_cnt, expected());
            end
        end
        n_checks++;
        if (tc_at !== 6 || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL one_shot_tc: got tc at %0d done=%b required 6 done=1", tc_at, done);
        end
    endtask

    task automatic test_auto_reload();
        int tc_seen;
        tc_seen = 0;
        tick(0, 1, 8'd3, 0, 0, 1, 1);
        for (int i = 1; i <= 13; i++) begin
            tick(0, 0, 8'd0, i == 1, 0, 1, 1);
            tc_seen += int'(tc);
            n_checks++;
            if ({count, busy, done, tc} !== expected() || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL auto_reload_cycle%0d: got %b required %b", i, {count, busy, done, tc}, expected());
            end
        end
        n_checks++;
        if (tc_seen !== 4) begin
            n_fail++;
            $display("[TB] FAIL auto_reload_tc_count: got %0d required 4", tc_seen);
        end
        tick(0, 0, 8'd0, 0, 1, 1, 0);
    endtask

    task automatic test_pause();
        int tc_at;
        logic st, sp, e;
        tc_at = -1;
        tick(0, 1, 8'd4, 0, 0, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            st = (i == 1) || (i == 9);
            sp = (i == 5);
            e  = !(i == 3 || i == 4);
            tick(0, 0, 8'd0, st, sp, e, 0);
            if (tc && tc_at < 0) tc_at = i;
            n_checks++;
            if ({count, busy, done, tc} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL pause_cycle%0d: got %b required %b", i, {count, busy, done, tc}, expected());
            end
            if (i >= 5 && i <= 8) begin
                n_checks++;
                if (count !== 8'd3 || busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL pause_hold%0d: got cnt=%0d busy=%b required cnt=3 busy=0", i, count, busy);
                end
            end
        end
        n_checks++;
        if (tc_at !== 12) begin
            n_fail++;
            $display("[TB] FAIL pause_tc_time: got %0d required 12", tc_at);
        end
    endtask

    task automatic test_boundaries();
        int guard;
        tick(0, 1, 8'd0, 0, 0, 1, 0);
        tick(0, 0, 8'd0, 1, 0, 1, 0);
        n_checks++;
        if ({count, busy, done, tc} !== {8'd0, 3'b011}) begin
            n_fail++;
            $display("[TB] FAIL zero_start: got %b required %b", {count, busy, done, tc}, {8'd0, 3'b011});
        end
        tick(0, 1, 8'd5, 0, 0, 1, 0);
        tick(0, 0, 8'd0, 1, 0, 1, 0);
        tick(0, 0, 8'd0, 1, 0, 1, 0);
        n_checks++;
        if ({count, busy, done, tc} !== {8'd4, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL start_in_run: got %b required %b", {count, busy, done, tc}, {8'd4, 3'b100});
        end
        guard = 0;
        while (count != 8'd1 && guard < 20) begin
            tick(0, 0, 8'd0, 0, 0, 1, 0);
            guard++;
        end
        tick(0, 1, 8'd7, 0, 0, 1, 0);
        n_checks++;
        if ({count, busy, done, tc} !== {8'd7, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL load_at_one: got %b required %b", {count, busy, done, tc}, {8'd7, 3'b000});
        end
    endtask

    task automatic test_reset_mid_run();
        int guard;
        bit tc_ever;
        tc_ever = 0;
        tick(0, 1, 8'd10, 0, 0, 1, 0);
        tick(0, 0, 8'd0, 1, 0, 1, 0);
        guard = 0;
        while (count != 8'd1 && guard < 30) begin
            tick(0, 0, 8'd0, 0, 0, 1, 0);
            tc_ever |= tc;
            guard++;
        end
        tick(1, 0, 8'd0, 0, 0, 1, 0);
        tc_ever |= tc;
        n_checks++;
        if ({count, busy, done, tc} !== 11'd0 || tc_ever || guard >= 30) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run: got %b tc_ever=%b guard=%0d required %b tc_ever=0", {count, busy, done, tc}, tc_ever, guard, 11'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, 8'($urandom_range(0, 6)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                 1'($urandom_range(0, 1)));
            n_checks++;
            if ({count, busy, done, tc} !== expected()) begin
                n_fail++;
                $display("[TB] FAIL random_cycle%0d: got %b required %b", i, {count, busy, done, tc}, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_boundaries();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer for the COUNTERS library, complementing the up-counting toggle chains by counting from a loaded value toward zero. Software or a controlling FSM loads a period, starts the timer, and receives a one-cycle terminal-count pulse when it expires, optionally reloading for periodic ticks. Sits beside the toggle-based counters as the standard timeout and tick source.

## Interface
- WIDTH, 8, width of count and load value
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; freezes decrementing only, control inputs act regardless
- load  in  1  capture load_val into count and reload register
- load_val  in  WIDTH  period value
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- auto_reload  in  1  sampled at terminal count; 1 = periodic mode
- count  out  WIDTH  current count, registered
- busy  out  1  high while in RUN
- done  out  1  high while in DONE
- tc  out  1  registered one-cycle terminal-count pulse

## Operation
- Reset is synchronous and active-high: state IDLE, count=0, reload_q=0, tc=0, busy=0, done=0.
- States:
  - IDLE: stopped or paused.
  - RUN: decrementing.
  - DONE: expired, one-shot mode.
- Priority each cycle: rst > load > start/stop > counting.
- load, any state: reload_q<=load_val, count<=load_val, state<=IDLE. start and stop in the same cycle are ignored.
- start:
  - IDLE, count!=0: RUN, count unchanged (resume).
  - IDLE, count==0: tc<=1, state DONE.
  - DONE, reload_q!=0: count<=reload_q, RUN.
  - DONE, reload_q==0: tc<=1, stay DONE.
  - Ignored in RUN.
- stop: in RUN, goes to IDLE with count held. Ignored in other states. Only one of start/stop is meaningful per state, so no conflict.
- RUN with en=1:
  - count>1: count<=count-1.
  - count==1, auto_reload=0: count<=0, tc<=1, state DONE.
  - count==1, auto_reload=1: count<=reload_q, tc<=1, stay RUN. If reload_q==1, tc pulses every enabled cycle.
- RUN with en=0: count and state hold, tc=0.
- tc is 0 in every cycle not listed above.
- busy = (state==RUN); done = (state==DONE). Both are decoded from the state register.
- count never wraps below 0. Arithmetic is WIDTH-bit unsigned.

## Timing
- start is sampled at edge E0. RUN is visible in the cycle after E0.
- With en held high, count decrements at E1..EN. tc is high during the cycle after EN, i.e. N+1 cycles after the start cycle. DONE or the reload is visible in the same cycle as tc.
- Auto-reload period: tc pulses every N enabled cycles after the first.
- Each en=0 cycle in RUN delays tc by exactly one cycle.
- load_val change takes effect only via load. reload_q changes only on load.
- rst asserted mid-RUN: next cycle shows the full reset values. No tc is emitted, even if count was 1.
- load in the same cycle as count==1 in RUN: load wins, no tc, IDLE with the new value.

## Structure
- State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) live as localparams in the shared counters_pkg include. Other counter FSMs use the same encodings.
- Single module, no sub-module. The count register and decrement are too small to justify a separate core.

## Test plan
- Reset/load sequence: rst for 2 cycles, then load_val=5 with load. Required: count=5, busy=0, done=0, tc=0.
- One-shot: with N=5, en=1, auto_reload=0, pulse start. Required: count 5,4,3,2,1,0; tc high exactly in the cycle 6 cycles after start; done=1 thereafter.
- Auto-reload: N=3, auto_reload=1, run 12 cycles. Required: tc every 3rd cycle, count cycles 3,2,1,3,…, busy stays 1.
- Pause/enable: N=4. Hold en=0 for 2 cycles mid-count, then pulse stop and later start. Required: tc delayed by exactly 2 cycles plus the stopped duration; count is held while stopped.
- Boundaries:
  - load_val=0, then start: tc 1 cycle later, done=1.
  - start while in RUN: no effect.
  - load at count==1: no tc, IDLE, new count.
- Reset mid-run: N=10, assert rst at count=1. Required: count=0, tc never asserted, IDLE.
